// File: rtl/rnn_mem_arbiter.sv
// Core/host arbiter for the shared RNN memory port, core-first with host anti-starvation.
// Optional stall counters are enabled by defining RNN_ARB_PERF_EN.
module rnn_mem_arbiter #(
  parameter int WAIT_MAX = 15,
  parameter int DW       = 20,
  parameter int AW       = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [2:0]    c_sel,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [2:0]    h_sel,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          m_ce,
  output logic          m_we,
  output logic [2:0]    m_sel,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
`ifdef RNN_ARB_PERF_EN
  ,
  output logic [15:0]   c_stall_cnt,
  output logic [15:0]   h_stall_cnt
`endif
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

  typedef enum logic {
    PRI_CORE,
    PRI_HOST
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          host_first;
  logic          any_gnt;
  logic          own1, own2;
  logic          rd1, rd2;
  logic [DW-1:0] c_rdata_q, h_rdata_q;

  // A host that has just hit the wait limit wins in that same cycle.
  assign host_first = (state == PRI_HOST) || (wait_cnt == WMAX);
  assign any_gnt    = c_gnt | h_gnt;

  always_comb begin
    c_gnt     = 1'b0;
    h_gnt     = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!reset) begin
      if (c_req && h_req) begin
        h_gnt = host_first;
        c_gnt = !host_first;
      end else begin
        c_gnt = c_req;
        h_gnt = h_req;
      end
    end
    unique case (state)
      PRI_CORE: if (wait_cnt == WMAX && !h_gnt) state_nxt = PRI_HOST;
      PRI_HOST: if (h_gnt) state_nxt = PRI_CORE;
    endcase
    if (h_gnt || !h_req)
      wait_nxt = '0;
    else if (wait_cnt != WMAX)
      wait_nxt = wait_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PRI_CORE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_ce      <= 1'b0;
      m_we      <= 1'b0;
      m_sel     <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      own1      <= 1'b0;
      own2      <= 1'b0;
      rd1       <= 1'b0;
      rd2       <= 1'b0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      m_ce <= any_gnt;
      if (any_gnt) begin
        m_we    <= h_gnt ? h_we    : c_we;
        m_sel   <= h_gnt ? h_sel   : c_sel;
        m_addr  <= h_gnt ? h_addr  : c_addr;
        m_wdata <= h_gnt ? h_wdata : c_wdata;
      end
      own1 <= h_gnt;
      rd1  <= h_gnt ? !h_we : (c_gnt && !c_we);
      own2 <= own1;
      rd2  <= rd1;
      if (c_rvalid) c_rdata_q <= m_rdata;
      if (h_rvalid) h_rdata_q <= m_rdata;
    end
  end

  assign c_rvalid = rd2 && !own2;
  assign h_rvalid = rd2 && own2;
  assign c_rdata  = c_rvalid ? m_rdata : c_rdata_q;
  assign h_rdata  = h_rvalid ? m_rdata : h_rdata_q;

`ifdef RNN_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      c_stall_cnt <= '0;
      h_stall_cnt <= '0;
    end else begin
      if (c_req && !c_gnt && c_stall_cnt != 16'hFFFF)
        c_stall_cnt <= c_stall_cnt + 16'd1;
      if (h_req && !h_gnt && h_stall_cnt != 16'hFFFF)
        h_stall_cnt <= h_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Randomized bench for rnn_mem_arbiter against a cycle-level behavioural model.
// Stall counter checks are compiled in when RNN_ARB_PERF_EN is defined.
module tb_rnn_mem_arbiter;

  localparam int WAIT_MAX = 15;
  localparam int DW = 20;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, h_req, h_we;
  logic [2:0]    c_sel, h_sel;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wdata, h_wdata;
  logic          c_gnt, h_gnt, c_rvalid, h_rvalid;
  logic [DW-1:0] c_rdata, h_rdata;
  logic          m_ce, m_we;
  logic [2:0]    m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
`ifdef RNN_ARB_PERF_EN
  logic [15:0]   c_stall_cnt, h_stall_cnt;
`endif

  always #5 clk = ~clk;

  rnn_mem_arbiter #(.WAIT_MAX(WAIT_MAX), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_sel(c_sel), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_sel(h_sel), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_ce(m_ce), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef RNN_ARB_PERF_EN
    , .c_stall_cnt(c_stall_cnt), .h_stall_cnt(h_stall_cnt)
`endif
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct {
    int due;
    bit owner;
  } rd_t;

  rd_t           rq[$];
  int            cyc = 0;
  int            hwait = 0;
  bit            owed = 0;
  bit            eg_c = 0, eg_h = 0;
  bit            og_h = 0;
  logic          e_ce = 0, e_we = 0;
  logic [2:0]    e_sel = 0;
  logic [AW-1:0] e_addr = 0;
  logic [DW-1:0] e_wdata = 0, e_crd = 0, e_hrd = 0;
  int            e_cst = 0, e_hst = 0;

  task automatic step(input bit rd_fix = 0);
    bit hf, rvc, rvh;
    if (!rd_fix) m_rdata = DW'($urandom);
    #2;
    hf = owed || (hwait == WAIT_MAX);
    eg_c = 0;
    eg_h = 0;
    if (!reset) begin
      if (c_req && h_req) begin
        eg_h = hf;
        eg_c = !hf;
      end else begin
        eg_c = c_req;
        eg_h = h_req;
      end
    end
    og_h = h_gnt;
    chk("c_gnt", c_gnt, eg_c);
    chk("h_gnt", h_gnt, eg_h);
    rvc = 0;
    rvh = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].owner) rvh = 1;
      else rvc = 1;
      void'(rq.pop_front());
    end
    if (rvc) e_crd = m_rdata;
    if (rvh) e_hrd = m_rdata;
    chk("c_rvalid", c_rvalid, rvc);
    chk("h_rvalid", h_rvalid, rvh);
    chk("c_rdata", c_rdata, e_crd);
    chk("h_rdata", h_rdata, e_hrd);
    if (!reset) begin
      if (c_req && !eg_c && e_cst < 65535) e_cst++;
      if (h_req && !eg_h && e_hst < 65535) e_hst++;
    end
    @(posedge clk);
    if (reset) begin
      hwait = 0;
      owed = 0;
      rq.delete();
      e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
      e_crd = 0; e_hrd = 0; e_cst = 0; e_hst = 0;
    end else begin
      e_ce = eg_c || eg_h;
      if (e_ce) begin
        e_we    = eg_h ? h_we    : c_we;
        e_sel   = eg_h ? h_sel   : c_sel;
        e_addr  = eg_h ? h_addr  : c_addr;
        e_wdata = eg_h ? h_wdata : c_wdata;
        if (!e_we) rq.push_back('{cyc + 2, eg_h});
      end
      if (!eg_h && hwait == WAIT_MAX) owed = 1;
      if (eg_h) owed = 0;
      if (eg_h || !h_req) hwait = 0;
      else if (hwait < WAIT_MAX) hwait++;
    end
    cyc++;
    #1;
    chk("m_ce", m_ce, e_ce);
    chk("m_we", m_we, e_we);
    chk("m_sel", m_sel, e_sel);
    chk("m_addr", m_addr, e_addr);
    chk("m_wdata", m_wdata, e_wdata);
  endtask

  task automatic do_reset();
    reset = 1;
    c_req = 0;
    h_req = 0;
    step();
    reset = 0;
  endtask

  initial begin
    int first;
    reset = 1;
    c_req = 0; c_we = 0; c_sel = 0; c_addr = 0; c_wdata = 0;
    h_req = 0; h_we = 0; h_sel = 0; h_addr = 0; h_wdata = 0;
    m_rdata = 0;
    @(posedge clk);
    #1;
    step();
    reset = 0;

    // lone core read
    c_req = 1; c_we = 0; c_sel = 3'b010; c_addr = 17'h0041;
    step();
    c_req = 0;
    step();
    m_rdata = 20'h0ABCD;
    step(1);
    chk("core_read_hold", c_rdata, 20'h0ABCD);

    // simultaneous requests, core first
    c_req = 1; c_we = 0; c_sel = 3'b001; c_addr = 17'h00100;
    h_req = 1; h_we = 1; h_sel = 3'b101; h_addr = 17'h1F00F;
    h_wdata = 20'h5A5A5;
    step();
    c_req = 0;
    step();
    h_req = 0;
    chk("host_wr_sel", m_sel, 3'b101);
    chk("host_wr_we", m_we, 1'b1);
    step();
    step();

    // starvation bound
    do_reset();
    c_req = 1; c_we = 1; h_req = 1; h_we = 0; h_sel = 3'b011;
    first = -1;
    for (int k = 0; k < 20 && first < 0; k++) begin
      c_addr = AW'(k);
      step();
      if (og_h) first = k;
    end
    chk("starve_cycle", first, WAIT_MAX);
    c_req = 0; h_req = 0;
    step();
    step();

    // alternating reads
    for (int k = 0; k < 10; k++) begin
      c_req = (k % 2 == 0);
      h_req = (k % 2 == 1);
      c_we = 0; h_we = 0;
      c_addr = AW'($urandom); h_addr = AW'($urandom);
      step();
    end
    c_req = 0; h_req = 0;
    step();
    step();

    // reset while a host read is in flight
    h_req = 1; h_we = 0; h_sel = 3'b100; h_addr = 17'h00777;
    step();
    h_req = 0;
    reset = 1;
    step();
    reset = 0;
    chk("rst_m_ce", m_ce, 1'b0);
    chk("rst_m_addr", m_addr, 0);
    step();
    step();

`ifdef RNN_ARB_PERF_EN
    do_reset();
    c_req = 1; c_we = 1; h_req = 1; h_we = 1;
    for (int k = 0; k < 10; k++) step();
    c_req = 0;
    step();
    h_req = 0;
    step();
    chk("perf_h_stall", h_stall_cnt, 16'd10);
    chk("perf_c_stall", c_stall_cnt, 16'd0);
`endif

    // randomized traffic, requests held until granted
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 249) == 0);
      if (!(c_req && !eg_c)) begin
        c_req = ($urandom_range(0, 2) != 0);
        c_we = 1'($urandom);
        c_sel = 3'($urandom);
        c_addr = AW'($urandom);
        c_wdata = DW'($urandom);
      end
      if (!(h_req && !eg_h)) begin
        h_req = ($urandom_range(0, 1) != 0);
        h_we = 1'($urandom);
        h_sel = 3'($urandom);
        h_addr = AW'($urandom);
        h_wdata = DW'($urandom);
      end
      step();
    end
    reset = 0;
    c_req = 0;
    h_req = 0;
    step();
    step();
    step();

`ifdef RNN_ARB_PERF_EN
    chk("end_c_stall", c_stall_cnt, e_cst);
    chk("end_h_stall", h_stall_cnt, e_hst);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
